// File: rtl/trng_harvester_if.sv
`default_nettype none
// ============================================================================
// Module   : trng_harvester_if
// Brief    : Valid/ready word stream carrying conditioned random words.
// Revision : 1.0 - initial release
// ============================================================================
interface trng_harvester_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;

  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface
`default_nettype wire

// File: rtl/trng_harvester.sv
`default_nettype none
// ============================================================================
// Module   : trng_harvester
// Brief    : Entropy sampler: sync, decimate, repetition-count test, Von
//            Neumann debias and word packing onto a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module trng_harvester #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int RCT_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              raw_a,
  input  logic              raw_b,
  input  logic              clr_fail,
  output logic              health_fail,
  trng_harvester_if.master  rnd
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(RCT_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] FULL_CNT = BW'(WIDTH);
  localparam logic [RW-1:0] RUN_MAX  = RW'(RCT_LIMIT);

  typedef enum logic [0:0] {VN_EMPTY = 1'b0, VN_HAVE = 1'b1} vn_state_t;

  logic            sync_a1, sync_a2, sync_b1, sync_b2;
  logic            sample, strobe;
  logic [CW-1:0]   div_cnt;
  logic            prev, primed, trip;
  logic [RW-1:0]   run, run_next;
  vn_state_t       vn_state, vn_next;
  logic            first_bit, emit;
  logic [WIDTH-1:0] shreg, word_now;
  logic [BW-1:0]   bit_cnt, cnt_now;
  logic            fill, out_free, xfer;

  assign sample = sync_a2 ^ sync_b2;
  assign strobe = en && (div_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a1 <= 1'b0;
      sync_a2 <= 1'b0;
      sync_b1 <= 1'b0;
      sync_b2 <= 1'b0;
      div_cnt <= '0;
    end else begin
      sync_a1 <= raw_a;
      sync_a2 <= sync_a1;
      sync_b1 <= raw_b;
      sync_b2 <= sync_b1;
      if (!en || strobe) div_cnt <= '0;
      else               div_cnt <= div_cnt + 1'b1;
    end
  end

  // run saturates at the limit so a held failure never re-trips
  always_comb begin
    run_next = RW'(1);
    if (primed && (sample == prev))
      run_next = (run == RUN_MAX) ? RUN_MAX : run + 1'b1;
    trip = strobe && (run_next == RUN_MAX) && (run != RUN_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= 1'b0;
      primed      <= 1'b0;
      run         <= '0;
      health_fail <= 1'b0;
    end else begin
      if (strobe) begin
        prev   <= sample;
        primed <= 1'b1;
      end
      if (!en) primed <= 1'b0;
      if (trip)          run <= run_next;
      else if (clr_fail) run <= '0;
      else if (strobe)   run <= run_next;
      if (trip)          health_fail <= 1'b1;
      else if (clr_fail) health_fail <= 1'b0;
    end
  end

  always_comb begin
    vn_next = vn_state;
    emit    = 1'b0;
    if (!en || trip) begin
      vn_next = VN_EMPTY;
    end else if (strobe) begin
      if (vn_state == VN_EMPTY) begin
        vn_next = VN_HAVE;
      end else begin
        vn_next = VN_EMPTY;
        emit    = (first_bit != sample) && !health_fail;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_state  <= VN_EMPTY;
      first_bit <= 1'b0;
    end else begin
      vn_state <= vn_next;
      if (strobe && (vn_state == VN_EMPTY)) first_bit <= sample;
    end
  end

  // word_now already holds the incoming bit so a free output loads on the same edge
  always_comb begin
    fill     = emit && (bit_cnt != FULL_CNT);
    word_now = shreg | (WIDTH'(fill & first_bit) << bit_cnt);
    cnt_now  = bit_cnt + BW'(fill);
    out_free = !rnd.rnd_valid || rnd.rnd_ready;
    xfer     = (cnt_now == FULL_CNT) && out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      rnd.rnd_data  <= '0;
      rnd.rnd_valid <= 1'b0;
    end else if (trip) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      rnd.rnd_valid <= 1'b0;
    end else if (xfer) begin
      rnd.rnd_data  <= word_now;
      rnd.rnd_valid <= 1'b1;
      shreg         <= '0;
      bit_cnt       <= '0;
    end else begin
      shreg   <= word_now;
      bit_cnt <= cnt_now;
      if (rnd.rnd_ready) rnd.rnd_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trng_harvester.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_harvester
// Brief    : Directed + random bench with a strobe-level queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_harvester;
  localparam int WIDTH = 8;
  localparam int DIV   = 4;
  localparam int LIMIT = 32;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic raw_a = 1'b0, raw_b = 1'b0, clr_fail = 1'b0;
  logic health_fail;

  trng_harvester_if #(.WIDTH(WIDTH)) bus ();

  trng_harvester #(.WIDTH(WIDTH), .DIV(DIV), .RCT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .raw_a(raw_a), .raw_b(raw_b),
    .clr_fail(clr_fail), .health_fail(health_fail), .rnd(bus.master)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;

  // reference state: pending VN sample, previous RCT sample, run length,
  // unpacked bits and the words owed to the consumer (head = on the bus)
  int               m_pend, m_prev, m_run;
  bit               m_fail;
  bit               m_bits[$];
  logic [WIDTH-1:0] m_words[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = -1; m_prev = -1; m_run = 0; m_fail = 1'b0;
    m_bits.delete(); m_words.delete();
  endtask

  function automatic logic [WIDTH-1:0] pack_bits();
    logic [WIDTH-1:0] w = '0;
    for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
    return w;
  endfunction

  task automatic model_edge(bit strb, bit v);
    bit rdy = bus.rnd_ready;
    bit fail_old = m_fail;
    bit free;
    int old_run = m_run;
    if (!en) begin m_pend = -1; m_prev = -1; end
    if (strb) begin
      m_run  = (m_prev == int'(v)) ? ((m_run < LIMIT) ? m_run + 1 : LIMIT) : 1;
      m_prev = v;
      if (m_run == LIMIT && old_run < LIMIT) begin
        m_fail = 1'b1; m_pend = -1; m_bits.delete(); m_words.delete();
        return;
      end
    end
    if (clr_fail) begin m_fail = 1'b0; m_run = 0; end
    if (strb) begin
      if (m_pend < 0) m_pend = v;
      else begin
        if (m_pend != int'(v) && !fail_old && m_bits.size() < WIDTH)
          m_bits.push_back(m_pend[0]);
        m_pend = -1;
      end
    end
    free = (m_words.size() == 0) || rdy;
    if (m_words.size() > 0 && rdy) void'(m_words.pop_front());
    if (m_bits.size() == WIDTH && free) begin
      m_words.push_back(pack_bits());
      m_bits.delete();
    end
  endtask

  task automatic tick(bit strb, bit v);
    @(posedge clk);
    model_edge(strb, v);
    #1;
    check("valid", bus.rnd_valid, m_words.size() > 0);
    if (m_words.size() > 0) check("data", bus.rnd_data, m_words[0]);
    check("health", health_fail, m_fail);
  endtask

  // one decimation period; the sample v is what the strobe at its end sees
  task automatic feed(bit v, bit rdy_rand = 1'b0, bit clr = 1'b0);
    raw_b = 1'($urandom_range(0, 1));
    raw_a = v ^ raw_b;
    for (int i = 0; i < DIV; i++) begin
      if (rdy_rand) bus.rnd_ready = 1'($urandom_range(0, 1));
      clr_fail = clr && (i == 0);
      tick(i == DIV - 1, v);
    end
    clr_fail = 1'b0;
  endtask

  task automatic pause(int n, bit rdy);
    en = 1'b0;
    bus.rnd_ready = rdy;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    bus.rnd_ready = 1'b0;
    en = 1'b1;
  endtask

  task automatic pairs(int n);
    bit x;
    for (int i = 0; i < n; i++) begin
      x = 1'($urandom_range(0, 1));
      feed(x); feed(!x);
    end
  endtask

  initial begin
    model_reset();
    bus.rnd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.rnd_valid, 0);
    check("rst_data", bus.rnd_data, 0);
    check("rst_health", health_fail, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // debias and pack: (1,0)x4 then (0,1)x4
    for (int i = 0; i < 4; i++) begin feed(1); feed(0); end
    for (int i = 0; i < 4; i++) begin feed(0); feed(1); end
    check("word_0f_valid", bus.rnd_valid, 1);
    check("word_0f", bus.rnd_data, 8'h0F);
    pause(2, 1'b1);

    // equal pairs discarded
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin feed(1); feed(1); end
      if (i == 5) begin feed(0); feed(0); end
      feed(1); feed(0);
    end
    check("word_ff_valid", bus.rnd_valid, 1);
    check("word_ff", bus.rnd_data, 8'hFF);
    pause(2, 1'b1);

    // random samples with random backpressure
    repeat (150) feed(1'($urandom_range(0, 1)), 1'b1);
    pause(3, 1'b1);

    // backpressure: three words' worth, third is dropped
    pairs(3 * WIDTH);
    check("bp_held", bus.rnd_valid, 1);
    pause(1, 1'b1);
    check("bp_reload", bus.rnd_valid, 1);
    pause(1, 1'b1);
    check("bp_third_dropped", bus.rnd_valid, 0);

    // enable gap inside a pair
    pairs(3);
    feed(1);
    pause(10, 1'b0);
    pairs(5);
    check("gap_word", bus.rnd_valid, 1);
    pause(2, 1'b1);

    // health: pending word flushed by a trip, then clear and re-trip
    pairs(WIDTH);
    check("hf_pending", bus.rnd_valid, 1);
    repeat (40) feed(0);
    check("hf_flush", bus.rnd_valid, 0);
    check("hf_set", health_fail, 1);
    feed(0, 1'b0, 1'b1);
    repeat (LIMIT - 2) feed(0);
    check("hf_cleared", health_fail, 0);
    feed(0);
    check("hf_retrip", health_fail, 1);
    repeat (10) feed(1'($urandom_range(0, 1)));
    feed(1, 1'b0, 1'b1);
    repeat (60) feed(1'($urandom_range(0, 1)), 1'b1);
    pause(3, 1'b1);

    // asynchronous reset mid-word with a word pending
    pairs(WIDTH);
    feed(1);
    check("pre_rst_valid", bus.rnd_valid, 1);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("arst_valid", bus.rnd_valid, 0);
    check("arst_data", bus.rnd_data, 0);
    check("arst_health", health_fail, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pairs(WIDTH - 2);
    check("post_rst_empty", bus.rnd_valid, 0);
    pairs(2);
    check("post_rst_word", bus.rnd_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
